alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have ports clk (input, 1, rising-edge clock) and rst_n (input, 1); reset is asynchronous and active-low, and the block uses one clock.
REQ-002 The block SHALL have reqN_valid (input, 1, N=0,1): requester N presents an operation.
REQ-003 The block SHALL have reqN_ready (output, 1, N=0,1): the operation on port N is accepted this cycle.
REQ-004 The block SHALL have reqN_a and reqN_b (input, 16, N=0,1): ALU operands A and B.
REQ-005 The block SHALL have reqN_op (input, 3, N=0,1): ALU opcode, where 0=B, 1=A+B, 2=A-B, 3=A&B, 4=A|B, 5=~B, and 6-7 give B.
REQ-006 The block SHALL have rspN_valid (output, 1, N=0,1): the result for requester N is held.
REQ-007 The block SHALL have rspN_ack (input, 1, N=0,1): requester N consumes its result.
REQ-008 The block SHALL have rsp_w (output, 16) and rsp_zero (output, 1): the registered result and zero flag, shared by both ports.
REQ-009 The block SHALL have alu_a and alu_b (output, 16) and alu_op (output, 3): the operands and opcode driven to the shared ALU.
REQ-010 The block SHALL have alu_w (input, 16) and alu_zero (input, 1): the ALU's combinational result and zero flag.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-012 In IDLE with at least one reqN_valid high, the block SHALL:
- select one winner;
- assert reqN_ready for the winner only, combinationally in that cycle;
- latch the winner's a, b and op into the operand registers;
- record the winner index and move to EXEC.
REQ-013 In IDLE with no valid request, the block SHALL remain in IDLE and keep both ready outputs low.
REQ-014 reqN_ready SHALL be low in EXEC and RESP; requests arriving then wait, and requesters hold them stable until accepted.
REQ-015 alu_a, alu_b and alu_op SHALL always be driven from the operand registers, so the ALU inputs are stable for all of EXEC.
REQ-016 In EXEC, the block SHALL capture alu_w and alu_zero into the rsp_w and rsp_zero registers and move to RESP.
REQ-017 In RESP, rspN_valid SHALL be high only for the recorded winner, and rsp_w and rsp_zero SHALL hold constant.
REQ-018 In RESP, the state SHALL change only when the winner's rspN_ack is high; the block then returns to IDLE and updates last_grant to the winner.
REQ-019 The non-winner's rspN_ack SHALL be ignored.
REQ-020 Latency SHALL be as follows:
- accept in cycle T;
- rspN_valid high from cycle T+2;
- minimum issue interval of 3 cycles, when the ack arrives in the first RESP cycle.
REQ-021 When both ports are valid in IDLE, the round-robin tie-break SHALL grant the port not equal to last_grant.
REQ-022 When only one port is valid, that port SHALL win regardless of last_grant.
REQ-023 A new request SHALL NOT be accepted in the same cycle as the RESP ack; acceptance occurs in the following IDLE cycle at the earliest.
REQ-024 Result width SHALL be 16 bits with no carry or overflow output; the ALU's wrap-around arithmetic is passed through unchanged.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously enter IDLE.
REQ-026 During and after reset, the following SHALL be 0: operand registers, alu_a, alu_b, alu_op, rsp_w, rsp_zero, both ready outputs and both rspN_valid outputs.
REQ-027 During and after reset, last_grant SHALL be 1, so port 0 wins the first tie.
REQ-028 A reset asserted in EXEC or RESP SHALL discard the in-flight operation, with no response delivered after reset is released.

Configuration
REQ-029 With macro ALU_ARB_FIXED_PRIO_EN defined, port 0 SHALL win every tie, and last_grant SHALL still be maintained but not used.
REQ-030 With ALU_ARB_FIXED_PRIO_EN undefined, the round-robin behaviour of REQ-021 SHALL apply.

Verification
REQ-031 Single op: after reset, port 0 sends a=16'h0005, b=16'h0003, op=1 and holds rsp0_ack=1 -> req0_ready in cycle T; rsp0_valid in T+2 with rsp_w=16'h0008 and rsp_zero=0; IDLE again in T+3.
REQ-032 Zero and wrap-around: port 1 sends a=16'h0007, b=16'h0007, op=2 -> rsp_w=0 and rsp_zero=1; then a=16'hFFFF, b=16'h0001, op=1 -> rsp_w=0 and rsp_zero=1.
REQ-033 Round-robin: both ports are valid continuously with immediate acks -> grants alternate 0,1,0,1 and each issue takes 3 cycles.
REQ-034 Fixed priority: with ALU_ARB_FIXED_PRIO_EN defined, both ports are valid continuously and port 0 stays valid -> port 0 is granted every time and port 1 is never granted.
REQ-035 Backpressure and reset: port 0 is granted and rsp0_ack is held low for 5 cycles, then asserted -> rsp0_valid, rsp_w and rsp_zero are stable for all 6 cycles and rsp1_ack is ignored; a repeat with rst_n pulsed low in RESP -> rsp0_valid drops to 0 immediately and no result appears after reset.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of alternating.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ack,
  output logic        rsp1_valid,
  input  logic        rsp1_ack,
  output logic [15:0] rsp_w,
  output logic        rsp_zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_w,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [2:0]  op_q, op_d;
  logic        win_q, win_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] rsp_w_q, rsp_w_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        any_valid;
  logic        grant;

  // grant is the winning port index when any_valid is set
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant_q;
`endif
    end else begin
      grant = req1_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    rsp_w_d      = rsp_w_q;
    rsp_zero_d   = rsp_zero_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (state_q)
      StIdle: begin
        // rst_n gate keeps ready low while reset holds the FSM in IDLE
        if (any_valid && rst_n) begin
          req0_ready = ~grant;
          req1_ready = grant;
          opa_d      = grant ? req1_a  : req0_a;
          opb_d      = grant ? req1_b  : req0_b;
          op_d       = grant ? req1_op : req0_op;
          win_d      = grant;
          state_d    = StExec;
        end
      end
      StExec: begin
        rsp_w_d    = alu_w;
        rsp_zero_d = alu_zero;
        state_d    = StResp;
      end
      StResp: begin
        rsp0_valid = ~win_q;
        rsp1_valid = win_q;
        if (win_q ? rsp1_ack : rsp0_ack) begin
          last_grant_d = win_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      win_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_w_q      <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
      rsp_w_q      <= rsp_w_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_a    = opa_q;
  assign alu_b    = opb_q;
  assign alu_op   = op_q;
  assign rsp_w    = rsp_w_q;
  assign rsp_zero = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model. Define ALU_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_alu_arbiter;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ack, rsp1_valid, rsp1_ack;
  logic [15:0] rsp_w, alu_a, alu_b, alu_w;
  logic        rsp_zero, alu_zero;
  logic [2:0]  alu_op;

  int n_checks = 0;
  int n_pass   = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ack   (rsp0_ack),
    .rsp1_valid (rsp1_valid),
    .rsp1_ack   (rsp1_ack),
    .rsp_w      (rsp_w),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_w      (alu_w),
    .alu_zero   (alu_zero)
  );

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return ~b;
      default: return b;
    endcase
  endfunction

  // Shared ALU lives in the bench
  always_comb begin
    alu_w    = alu_ref(alu_a, alu_b, alu_op);
    alu_zero = (alu_w == 16'h0);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ack   = 1'b0; rsp1_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h5678; req0_op = 3'd1;
    req1_valid = 1'b1; req1_a = 16'h9abc; req1_b = 16'hdef0; req1_op = 3'd2;
    #3;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    else n_pass++;
    n_checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00)
      $display("FAIL reset_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid});
    else n_pass++;
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== 35'h0)
      $display("FAIL reset_alu_in: got %h %h %h want 0", alu_a, alu_b, alu_op);
    else n_pass++;
    n_checks++;
    if ({rsp_w, rsp_zero} !== 17'h0)
      $display("FAIL reset_rsp: got %h %b want 0 0", rsp_w, rsp_zero);
    else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    // last_grant comes out of reset as 1, so port 0 takes the first tie
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL reset_first_tie: got %b want 01", {req1_ready, req0_ready});
    else n_pass++;
    n_checks++;
    if (alu_a !== 16'h0)
      $display("FAIL reset_alu_a_after: got %h want 0000", alu_a);
    else n_pass++;
  endtask

  task automatic test_single_op();
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h0005; req0_b = 16'h0003; req0_op = 3'd1; rsp0_ack = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL single_accept: got %b want 01", {req1_ready, req0_ready});
    else n_pass++;
    step();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if ({rsp0_valid, req0_ready} !== 2'b00)
      $display("FAIL single_exec: got valid=%b ready=%b want 0 0", rsp0_valid, req0_ready);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b01)
      $display("FAIL single_rsp_valid: got %b want 01", {rsp1_valid, rsp0_valid});
    else n_pass++;
    n_checks++;
    if ({rsp_w, rsp_zero} !== {16'h0008, 1'b0})
      $display("FAIL single_result: got %h %b want 0008 0", rsp_w, rsp_zero);
    else n_pass++;
    step();
    req0_valid = 1'b1;
    #1;
    n_checks++;
    if ({rsp0_valid, req0_ready} !== 2'b01)
      $display("FAIL single_idle_t3: got valid=%b ready=%b want 0 1", rsp0_valid, req0_ready);
    else n_pass++;
    step();
    req0_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_zero_wrap();
    do_reset();
    req1_valid = 1'b1; req1_a = 16'h0007; req1_b = 16'h0007; req1_op = 3'd2; rsp1_ack = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b10)
      $display("FAIL zero_accept: got %b want 10", {req1_ready, req0_ready});
    else n_pass++;
    step();
    req1_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if ({rsp1_valid, rsp0_valid, rsp_w, rsp_zero} !== {2'b10, 16'h0, 1'b1})
      $display("FAIL zero_sub: got %b%b %h %b want 10 0000 1", rsp1_valid, rsp0_valid, rsp_w,
               rsp_zero);
    else n_pass++;
    step();
    req1_valid = 1'b1; req1_a = 16'hffff; req1_b = 16'h0001; req1_op = 3'd1;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1)
      $display("FAIL wrap_accept: got %b want 1", req1_ready);
    else n_pass++;
    step();
    req1_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if ({rsp1_valid, rsp_w, rsp_zero} !== {1'b1, 16'h0, 1'b1})
      $display("FAIL wrap_add: got %b %h %b want 1 0000 1", rsp1_valid, rsp_w, rsp_zero);
    else n_pass++;
    step();
  endtask

  task automatic test_arbitration();
    bit          last, g, ew, rw, newop;
    int          prev, resp_cyc, ng;
    logic [15:0] er;
    do_reset();
    last = 1'b1; prev = -1; resp_cyc = -1; ng = 0; newop = 1'b0; rw = 1'b0; er = '0;
    req0_valid = 1'b1; req0_a = 16'($urandom); req0_b = 16'($urandom);
    req0_op = 3'($urandom_range(0, 7));
    req1_valid = 1'b1; req1_a = 16'($urandom); req1_b = 16'($urandom);
    req1_op = 3'($urandom_range(0, 7));
    rsp0_ack = 1'b1; rsp1_ack = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (cyc == resp_cyc) begin
        n_checks++;
        if ({rsp1_valid, rsp0_valid, rsp_w} !== {rw, ~rw, er})
          $display("FAIL arb_rsp: got %b%b %h want %b%b %h", rsp1_valid, rsp0_valid, rsp_w,
                   rw, ~rw, er);
        else n_pass++;
      end
      if (req0_ready || req1_ready) begin
        g = req1_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
        ew = 1'b0;
`else
        ew = ~last;
`endif
        n_checks++;
        if ({req1_ready, req0_ready} !== {ew, ~ew})
          $display("FAIL arb_winner: got %b want %b%b at cycle %0d", {req1_ready, req0_ready},
                   ew, ~ew, cyc);
        else n_pass++;
        if (prev >= 0) begin
          n_checks++;
          if (cyc - prev != 3)
            $display("FAIL arb_interval: got %0d want 3", cyc - prev);
          else n_pass++;
        end
        er = g ? alu_ref(req1_a, req1_b, req1_op) : alu_ref(req0_a, req0_b, req0_op);
        rw = g; resp_cyc = cyc + 2; prev = cyc; last = g; ng++; newop = 1'b1;
      end
      step();
      if (newop) begin
        if (rw) begin
          req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 3'($urandom_range(0, 7));
        end else begin
          req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 3'($urandom_range(0, 7));
        end
        newop = 1'b0;
      end
    end
    n_checks++;
    if (ng != 10)
      $display("FAIL arb_grant_count: got %0d want 10", ng);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [15:0] er;
    do_reset();
    req0_valid = 1'b1; req0_a = 16'($urandom); req0_b = 16'($urandom);
    req0_op = 3'($urandom_range(1, 5));
    er = alu_ref(req0_a, req0_b, req0_op);
    rsp1_ack = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) rsp0_ack = 1'b1;
      #1;
      n_checks++;
      if ({rsp1_valid, rsp0_valid, rsp_w, rsp_zero} !== {2'b01, er, er == 16'h0})
        $display("FAIL bp_hold: got %b%b %h %b want 01 %h %b at %0d", rsp1_valid, rsp0_valid,
                 rsp_w, rsp_zero, er, er == 16'h0, i);
      else n_pass++;
      step();
    end
    #1;
    n_checks++;
    if (rsp0_valid !== 1'b0)
      $display("FAIL bp_release: got %b want 0", rsp0_valid);
    else n_pass++;

    do_reset();
    req0_valid = 1'b1; req0_a = 16'h00f0; req0_b = 16'h0f00; req0_op = 3'd4;
    step();
    req0_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if ({rsp0_valid, rsp_w} !== {1'b1, 16'h0ff0})
      $display("FAIL rst_pre: got %b %h want 1 0ff0", rsp0_valid, rsp_w);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp0_valid, rsp_w, rsp_zero} !== 18'h0)
      $display("FAIL rst_drop: got %b %h %b want 0 0000 0", rsp0_valid, rsp_w, rsp_zero);
    else n_pass++;
    step();
    rst_n = 1'b1; rsp0_ack = 1'b1; rsp1_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({rsp1_valid, rsp0_valid} !== 2'b00)
        $display("FAIL rst_no_rsp: got %b want 00 at %0d", {rsp1_valid, rsp0_valid}, i);
      else n_pass++;
      step();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit          pv[2];
    logic [15:0] pa[2], pb[2];
    logic [2:0]  po[2];
    bit          m_idle, m_last, m_win, g, any, r0, r1, in_resp;
    int          m_age;
    logic [15:0] m_res;
    do_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    m_idle = 1'b1; m_last = 1'b1; m_win = 1'b0; m_age = 0; m_res = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) == 0) begin
          pv[p] = 1'b1;
          pa[p] = 16'($urandom);
          pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : 16'($urandom);
          po[p] = 3'($urandom_range(0, 7));
        end
      end
      req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = po[0];
      req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = po[1];
      rsp0_ack = 1'($urandom_range(0, 1));
      rsp1_ack = 1'($urandom_range(0, 1));
      #1;
      any = pv[0] | pv[1];
      if (pv[0] && pv[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        g = 1'b0;
`else
        g = ~m_last;
`endif
      end else begin
        g = pv[1];
      end
      r0 = m_idle && any && !g;
      r1 = m_idle && any && g;
      n_checks++;
      if ({req1_ready, req0_ready} !== {r1, r0})
        $display("FAIL rand_ready: got %b want %b%b at %0d", {req1_ready, req0_ready}, r1, r0,
                 cyc);
      else n_pass++;
      in_resp = !m_idle && m_age >= 2;
      n_checks++;
      if ({rsp1_valid, rsp0_valid} !== {in_resp && m_win, in_resp && !m_win})
        $display("FAIL rand_rsp_valid: got %b want %b%b at %0d", {rsp1_valid, rsp0_valid},
                 in_resp && m_win, in_resp && !m_win, cyc);
      else n_pass++;
      if (in_resp) begin
        n_checks++;
        if ({rsp_w, rsp_zero} !== {m_res, m_res == 16'h0})
          $display("FAIL rand_result: got %h %b want %h %b at %0d", rsp_w, rsp_zero, m_res,
                   m_res == 16'h0, cyc);
        else n_pass++;
      end
      if (m_idle) begin
        if (any) begin
          m_idle = 1'b0; m_age = 1; m_win = g;
          m_res = alu_ref(pa[g], pb[g], po[g]);
          pv[g] = 1'b0;
        end
      end else if (m_age < 2) begin
        m_age++;
      end else if (m_win ? rsp1_ack : rsp0_ack) begin
        m_idle = 1'b1; m_last = m_win;
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_zero_wrap();
    test_arbitration();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
